// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single synchronous memory port between the CPU load/store
//   path (port C) and the DMA/UART program loader (port D). One grant per
//   cycle; read data returns one cycle after the grant and is tagged back
//   to the requester that issued it.
//
//   Handshake: a requester raises x_req with a stable payload; the beat is
//   accepted in exactly the cycle x_gnt is high. A refused requester keeps
//   x_req and its payload unchanged until granted. x_rvalid is a one-cycle
//   pulse, with no back-pressure, in the cycle after an accepted read.
//
//   Optional build macro: DMEM_ARB_RR_EN
//     defined   : contention between C and D is resolved round-robin using a
//                 last-winner flop (the port that did not win last time wins).
//     undefined : contention is resolved in favour of the CPU.
//   The D-lock and D-starvation rules take precedence in both builds.

module dmem_port_arbiter #(
   parameter int AW       = 14,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          c_req,
   input  logic [3:0]    c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          d_req,
   input  logic          d_lock,
   input  logic [3:0]    d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_din,
   output logic [3:0]    m_we,
   input  logic [DW-1:0] m_dout
);

   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

   logic [WCW-1:0] r_wait_cnt;   // cycles D has been refused in a row
   logic           r_lock_q;     // D owns the port for back-to-back beats
   logic [1:0]     r_rd_tag_q;   // {C read in flight, D read in flight}

   logic w_wait_full;
   logic w_c_wins_tie;
   logic w_c_gnt;
   logic w_d_gnt;

`ifdef DMEM_ARB_RR_EN
   logic r_last_q;               // last winner: 0 = C, 1 = D

   // Remember who won the most recent granted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_q <= 1'b0;
      end else if (w_c_gnt || w_d_gnt) begin
         r_last_q <= w_d_gnt;
      end
   end

   // On contention the port that did not win last time gets the beat.
   always_comb w_c_wins_tie = r_last_q;
`else
   // On contention the CPU always gets the beat.
   always_comb w_c_wins_tie = 1'b1;
`endif

   // D has been refused long enough that it must be served next.
   always_comb w_wait_full = (r_wait_cnt == WAIT_MAX);

   // Grant selection: lock, then starvation guard, then tie-break, then lone requester.
   always_comb begin
      w_c_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (rst_n) begin
         if (r_lock_q) begin
            // CPU stays blocked while the lock is held, even if D pauses.
            w_d_gnt = d_req;
         end else if (w_wait_full && d_req) begin
            w_d_gnt = 1'b1;
         end else if (c_req && d_req) begin
            w_c_gnt = w_c_wins_tie;
            w_d_gnt = !w_c_wins_tie;
         end else if (c_req) begin
            w_c_gnt = 1'b1;
         end else if (d_req) begin
            w_d_gnt = 1'b1;
         end
      end
   end

   // Memory-side mux; with no winner the CPU payload is presented but not written.
   always_comb begin
      m_addr = w_d_gnt ? d_addr  : c_addr;
      m_din  = w_d_gnt ? d_wdata : c_wdata;
      if (w_c_gnt) begin
         m_we = c_we;
      end else if (w_d_gnt) begin
         m_we = d_we;
      end else begin
         m_we = 4'b0000;
      end
   end

   // Starvation counter for D: counts refused cycles, saturating at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (w_d_gnt || !d_req) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_MAX) begin
         r_wait_cnt <= r_wait_cnt + WCW'(1);
      end
   end

   // Lock flop: taken on a locked D grant, released when D drops lock or request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_q <= 1'b0;
      end else if (!d_lock || !d_req) begin
         r_lock_q <= 1'b0;
      end else if (w_d_gnt) begin
         r_lock_q <= 1'b1;
      end
   end

   // Tag granted reads so the returning data is steered to the right requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_tag_q <= 2'b00;
      end else begin
         r_rd_tag_q <= {w_c_gnt && (c_we == 4'b0000), w_d_gnt && (d_we == 4'b0000)};
      end
   end

   // Return path: data is forced to zero whenever it is not valid.
   always_comb begin
      c_gnt    = w_c_gnt;
      d_gnt    = w_d_gnt;
      c_rvalid = r_rd_tag_q[1];
      d_rvalid = r_rd_tag_q[0];
      c_rdata  = r_rd_tag_q[1] ? m_dout : '0;
      d_rdata  = r_rd_tag_q[0] ? m_dout : '0;
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Drives directed and randomized traffic into dmem_port_arbiter, with a
//   behavioural memory on the port side. A reference model predicts grants
//   and memory-side signals each cycle and queues the expected read data; an
//   independent monitor pops those queues whenever a port shows rvalid.

module tb_dmem_port_arbiter;

   localparam int AW       = 14;
   localparam int DW       = 32;
   localparam int MAX_WAIT = 8;
   localparam int DEPTH    = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic          c_req, c_gnt, c_rvalid;
   logic [3:0]    c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata, c_rdata;
   logic          d_req, d_lock, d_gnt, d_rvalid;
   logic [3:0]    d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_din, m_dout;
   logic [3:0]    m_we;

   dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_lock(d_lock), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_din(m_din), .m_we(m_we), .m_dout(m_dout)
   );

   // ---------------- behavioural synchronous memory ----------------
   logic [DW-1:0] tb_mem [0:DEPTH-1];

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (m_we[b]) tb_mem[m_addr[4:0]][8*b +: 8] <= m_din[8*b +: 8];
      end
      m_dout <= tb_mem[m_addr[4:0]];
   end

   // ---------------- reference model state ----------------
   logic [DW-1:0] model_mem [0:DEPTH-1];
   int            model_wait;
   bit            model_lock;
   bit            last_c_gnt, last_d_gnt;

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_c_q[$];
   logic [DW-1:0] exp_d_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: consume expected read data whenever a port presents rvalid.
   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (c_rvalid === 1'b1) begin
         if (exp_c_q.size() == 0) begin
            chk("c_rvalid_unexpected", 64'(c_rvalid), 64'd0);
         end else begin
            e = exp_c_q.pop_front();
            chk("c_rdata", 64'(c_rdata), 64'(e));
         end
      end else begin
         chk("c_rdata_idle_zero", 64'(c_rdata), 64'd0);
      end
      if (d_rvalid === 1'b1) begin
         if (exp_d_q.size() == 0) begin
            chk("d_rvalid_unexpected", 64'(d_rvalid), 64'd0);
         end else begin
            e = exp_d_q.pop_front();
            chk("d_rdata", 64'(d_rdata), 64'(e));
         end
      end else begin
         chk("d_rdata_idle_zero", 64'(d_rdata), 64'd0);
      end
   end

   // ---------------- driver ----------------
   // Applies one cycle of inputs (caller is at a negedge), checks the
   // combinational response against the model, then advances the model.
   task automatic drive_cycle(input logic cr, input logic [3:0] cw, input logic [AW-1:0] ca,
                              input logic [DW-1:0] cd, input logic dr, input logic dl,
                              input logic [3:0] dw, input logic [AW-1:0] da,
                              input logic [DW-1:0] dd);
      bit ec, ed;
      logic [3:0] ewe;
      c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
      d_req = dr; d_lock = dl; d_we = dw; d_addr = da; d_wdata = dd;
      #1;
      // Who wins this cycle, straight from the policy rules.
      ec = 1'b0;
      ed = 1'b0;
      if (rst_n) begin
         ed = dr && (model_lock || model_wait == MAX_WAIT || !cr);
         ec = cr && !ed && !model_lock;
      end
      ewe = ec ? cw : (ed ? dw : 4'b0000);
      chk("c_gnt", 64'(c_gnt), 64'(ec));
      chk("d_gnt", 64'(d_gnt), 64'(ed));
      chk("m_we", 64'(m_we), 64'(ewe));
      chk("m_addr", 64'(m_addr), 64'(ed ? da : ca));
      chk("m_din", 64'(m_din), 64'(ed ? dd : cd));
      // Accepted beats: reads queue the expected data, writes update the model memory.
      if (ec) begin
         if (cw == 4'b0000) exp_c_q.push_back(model_mem[ca[4:0]]);
         for (int b = 0; b < 4; b++) if (cw[b]) model_mem[ca[4:0]][8*b +: 8] = cd[8*b +: 8];
      end
      if (ed) begin
         if (dw == 4'b0000) exp_d_q.push_back(model_mem[da[4:0]]);
         for (int b = 0; b < 4; b++) if (dw[b]) model_mem[da[4:0]][8*b +: 8] = dd[8*b +: 8];
      end
      // Next-cycle model state.
      if (!rst_n) begin
         model_wait = 0;
         model_lock = 1'b0;
      end else begin
         if (ed || !dr) model_wait = 0;
         else if (model_wait < MAX_WAIT) model_wait = model_wait + 1;
         model_lock = dr && dl && (model_lock || ed);
      end
      last_c_gnt = ec;
      last_d_gnt = ed;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      drive_cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b0, 4'h0, '0, '0);
   endtask

   // ---------------- stimulus ----------------
   logic          s_cr, s_dr, s_dl;
   logic [3:0]    s_cw, s_dw;
   logic [AW-1:0] s_ca, s_da;
   logic [DW-1:0] s_cd, s_dd;
   int first_d;
   int lock_beats;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         tb_mem[i]    = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
         model_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      end
      tb_mem[16]    = 32'hDEAD_BEEF;
      model_mem[16] = 32'hDEAD_BEEF;
      model_wait = 0;
      model_lock = 1'b0;
      last_c_gnt = 1'b0;
      last_d_gnt = 1'b0;
      s_cr = 1'b0; s_dr = 1'b0; s_dl = 1'b0;
      s_cw = '0; s_dw = '0; s_ca = '0; s_da = '0; s_cd = '0; s_dd = '0;

      // Reset: requests present but nothing may be granted.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_cycle(1'b1, 4'h0, 14'd3, 32'h0, 1'b1, 1'b0, 4'hF, 14'd4, 32'h5);
      end
      @(negedge clk);
      chk("rst_c_rvalid", 64'(c_rvalid), 64'd0);
      chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
      rst_n = 1'b1;
      drive_cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b0, 4'h0, '0, '0);

      // C read of 0x010.
      @(negedge clk);
      drive_cycle(1'b1, 4'h0, 14'h010, 32'h0, 1'b0, 1'b0, 4'h0, '0, '0);
      idle_cycle();

      // Contention: C wins until D has waited MAX_WAIT cycles.
      first_d = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         drive_cycle(1'b1, 4'h0, 14'd16, 32'h0, first_d < 0, 1'b0, 4'h0, 14'd17, 32'h0);
         if (d_gnt === 1'b1 && first_d < 0) first_d = k;
      end
      chk("contention_first_d_cycle", 64'(first_d), 64'd8);
      // Counter is cleared, so the next contention goes to C again.
      @(negedge clk);
      drive_cycle(1'b1, 4'h0, 14'd18, 32'h0, 1'b1, 1'b0, 4'h0, 14'd19, 32'h0);
      chk("post_grant_c_wins", 64'(c_gnt), 64'd1);
      idle_cycle();

      // Locked burst: four D writes while C keeps asking.
      lock_beats = 0;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         drive_cycle(b > 0, 4'h0, 14'd2, 32'h0, 1'b1, 1'b1, 4'hF, 14'(20 + b), 32'hA5A5_0000 + 32'(b));
         if (d_gnt === 1'b1 && m_we === 4'hF && c_gnt === 1'b0) lock_beats++;
      end
      chk("lock_consecutive_d", 64'(lock_beats), 64'd4);
      @(negedge clk);
      drive_cycle(1'b1, 4'h0, 14'd2, 32'h0, 1'b0, 1'b0, 4'h0, '0, '0);
      chk("lock_still_blocks_c", 64'(c_gnt), 64'd0);
      @(negedge clk);
      drive_cycle(1'b1, 4'h0, 14'd2, 32'h0, 1'b0, 1'b0, 4'h0, '0, '0);
      chk("lock_released_c", 64'(c_gnt), 64'd1);
      idle_cycle();
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         drive_cycle(1'b1, 4'h0, 14'(20 + b), 32'h0, 1'b0, 1'b0, 4'h0, '0, '0);
      end

      // Byte write then read back the merged word.
      @(negedge clk);
      drive_cycle(1'b1, 4'b0100, 14'd5, 32'h00AB_0000, 1'b0, 1'b0, 4'h0, '0, '0);
      @(negedge clk);
      drive_cycle(1'b1, 4'h0, 14'd5, 32'h0, 1'b0, 1'b0, 4'h0, '0, '0);
      idle_cycle();

      // Reset while a D read is in flight: its data must never appear.
      @(negedge clk);
      drive_cycle(1'b0, 4'h0, '0, '0, 1'b1, 1'b0, 4'h0, 14'd16, 32'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_d_q.delete();
      model_wait = 0;
      model_lock = 1'b0;
      @(negedge clk);
      chk("rst_mid_d_rvalid", 64'(d_rvalid), 64'd0);
      drive_cycle(1'b1, 4'hF, 14'd1, 32'h1234_5678, 1'b1, 1'b1, 4'hF, 14'd2, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_cycle(1'b0, 4'h0, '0, '0, 1'b0, 1'b0, 4'h0, '0, '0);

      // Randomized traffic honouring the hold-until-granted rule.
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (!(s_cr && !last_c_gnt)) begin
            s_cr = ($urandom_range(0, 99) < 55);
            s_cw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            s_ca = 14'($urandom_range(0, DEPTH - 1));
            s_cd = $urandom;
         end
         if (!(s_dr && !last_d_gnt)) begin
            s_dr = ($urandom_range(0, 99) < 50);
            s_dl = ($urandom_range(0, 99) < 35);
            s_dw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            s_da = 14'($urandom_range(0, DEPTH - 1));
            s_dd = $urandom;
         end
         drive_cycle(s_cr, s_cw, s_ca, s_cd, s_dr, s_dl, s_dw, s_da, s_dd);
      end

      // Drain and confirm every expected read came back.
      for (int i = 0; i < 3; i++) idle_cycle();
      chk("c_queue_drained", 64'(exp_c_q.size()), 64'd0);
      chk("d_queue_drained", 64'(exp_d_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
